project_mux_ctrl: RTL and testbench



---
 rtl/project_mux_ctrl_if.sv | 21 ++
 rtl/project_mux_ctrl.sv | 141 ++++++++++++++
 tb/tb_project_mux_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/project_mux_ctrl_if.sv
// rtl/project_mux_ctrl_if.sv - Wishbone slave bundle for the project mux controller
interface project_mux_ctrl_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/project_mux_ctrl.sv
// rtl/project_mux_ctrl.sv - Wishbone-controlled project pad mux with isolated switch gap
module project_mux_ctrl #(
   parameter int          NUM_PROJECTS  = 8,
   parameter int          IO_PADS       = 38,
   parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
   parameter int          SWITCH_GAP    = 16,
   parameter int          RESET_PROJECT = 0
) (
   input  logic                            wb_clk_i,
   input  logic                            wb_rst_n_i,
   project_mux_ctrl_if.slave               wb,
   input  logic [IO_PADS-1:0]              io_in,
   output logic [IO_PADS-1:0]              io_out,
   output logic [IO_PADS-1:0]              io_oeb,
   input  logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_out_i,
   input  logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_oeb_i,
   output logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_in_o,
   output logic [NUM_PROJECTS-1:0]         proj_rst_o
);
   localparam int             GW        = (SWITCH_GAP > 1) ? $clog2(SWITCH_GAP) : 1;
   localparam logic [GW-1:0]  GAP_LOAD  = GW'(SWITCH_GAP - 1);
   localparam logic [7:0]     RST_PROJ  = 8'(RESET_PROJECT);

   typedef enum logic {ST_RUN, ST_SWITCH} state_t;

   state_t                  state_q, state_d;
   logic [GW-1:0]           gap_q, gap_d;
   logic [7:0]              active_q, active_d;
   logic [7:0]              pending_q, pending_d;
   logic [NUM_PROJECTS-1:0] soft_q, soft_d;
   logic [15:0]             cnt_q, cnt_d;
   logic                    ack_q, ack_d;
   logic [31:0]             dat_q, dat_d;
   logic                    held_q, held_d;

   logic        valid, in_win, accept, do_wr, act_wr, busy;
   logic [1:0]  offs;
   logic [31:0] rd_data, rd_soft;

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         state_q   <= ST_RUN;
         gap_q     <= '0;
         active_q  <= RST_PROJ;
         pending_q <= RST_PROJ;
         soft_q    <= '0;
         cnt_q     <= '0;
         ack_q     <= 1'b0;
         dat_q     <= '0;
         held_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         gap_q     <= gap_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         soft_q    <= soft_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         dat_q     <= dat_d;
         held_q    <= held_d;
      end
   end

   always_comb begin
      valid   = wb.wbs_cyc_i & wb.wbs_stb_i;
      in_win  = (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
      // One ack per asserted request: held stays set until the master drops valid.
      accept  = valid & in_win & ~held_q;
      do_wr   = accept & wb.wbs_we_i & (wb.wbs_sel_i != 4'b0000);
      offs    = wb.wbs_adr_i[3:2];
      act_wr  = do_wr & (offs == 2'd0) & wb.wbs_sel_i[0];

      rd_soft = '0;
      rd_soft[NUM_PROJECTS-1:0] = soft_q;
      case (offs)
         2'd0:    rd_data = {24'b0, pending_q};
         2'd1:    rd_data = {8'b0, pending_q, active_q, 7'b0, state_q == ST_SWITCH};
         2'd2:    rd_data = rd_soft;
         default: rd_data = {16'b0, cnt_q};
      endcase

      held_d    = valid & (held_q | accept);
      ack_d     = accept;
      dat_d     = (accept & ~wb.wbs_we_i) ? rd_data : 32'b0;
      state_d   = state_q;
      gap_d     = gap_q;
      active_d  = active_q;
      pending_d = pending_q;
      soft_d    = soft_q;
      cnt_d     = cnt_q;

      if (do_wr && offs == 2'd2) begin
         for (int k = 0; k < NUM_PROJECTS; k++) begin
            if (wb.wbs_sel_i[k/8]) soft_d[k] = wb.wbs_dat_i[k];
         end
      end

      case (state_q)
         ST_RUN: begin
            if (act_wr) begin
               pending_d = wb.wbs_dat_i[7:0];
               if (wb.wbs_dat_i[7:0] != active_q) begin
                  state_d = ST_SWITCH;
                  gap_d   = GAP_LOAD;
               end
            end
         end
         default: begin
            if (act_wr) begin
               pending_d = wb.wbs_dat_i[7:0];
               gap_d     = GAP_LOAD;
            end else if (gap_q == '0) begin
               active_d = pending_q;
               cnt_d    = cnt_q + 16'd1;
               state_d  = ST_RUN;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      busy         = (state_q == ST_SWITCH);
      io_out       = '0;
      io_oeb       = '1;
      proj_io_in_o = '0;
      // An out-of-range active value matches no slot, so pads stay isolated.
      for (int k = 0; k < NUM_PROJECTS; k++) begin
         if (!busy && active_q == 8'(k)) begin
            io_out = proj_io_out_i[k*IO_PADS +: IO_PADS];
            io_oeb = proj_io_oeb_i[k*IO_PADS +: IO_PADS];
            proj_io_in_o[k*IO_PADS +: IO_PADS] = io_in;
         end
         proj_rst_o[k] = ~wb_rst_n_i | soft_q[k] | busy | (active_q != 8'(k));
      end
   end

   assign wb.wbs_ack_o = ack_q;
   assign wb.wbs_dat_o = dat_q;
endmodule

// File: tb/tb_project_mux_ctrl.sv
// tb/tb_project_mux_ctrl.sv - scoreboard bench for project_mux_ctrl against a deadline-based model
module tb_project_mux_ctrl;
   localparam int          NP   = 8;
   localparam int          IOP  = 38;
   localparam int          GAP  = 16;
   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam int          W    = NP * IOP;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   project_mux_ctrl_if wb();
   logic [IOP-1:0] io_in, io_out, io_oeb;
   logic [W-1:0]   p_out, p_oeb, p_in;
   logic [NP-1:0]  p_rst;

   project_mux_ctrl #(
      .NUM_PROJECTS(NP), .IO_PADS(IOP), .BASE_ADDR(BASE),
      .SWITCH_GAP(GAP), .RESET_PROJECT(0)
   ) dut (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb(wb),
      .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
      .proj_io_out_i(p_out), .proj_io_oeb_i(p_oeb),
      .proj_io_in_o(p_in), .proj_rst_o(p_rst)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0]  m_active = 8'd0;
   logic [7:0]  m_pending = 8'd0;
   logic        m_busy = 1'b0;
   int          m_sw_end = 0;
   logic [NP-1:0] m_soft = '0;
   logic [15:0] m_cnt = 16'd0;
   logic        m_ack = 1'b0;
   logic        m_held = 1'b0;
   int          edge_n = 0;
   bit          started = 1'b0;
   logic [31:0] exp_q[$];

   function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
      end
   endfunction

   task automatic model_step();
      logic [31:0] adr, dat, rdv;
      logic        inw, acc, actw, vld;
      int          off;
      edge_n++;
      started = 1'b1;
      if (!rst_n) begin
         m_active = 8'd0; m_pending = 8'd0; m_busy = 1'b0; m_soft = '0;
         m_cnt = 16'd0; m_ack = 1'b0; m_held = 1'b0;
         return;
      end
      adr  = wb.wbs_adr_i;
      dat  = wb.wbs_dat_i;
      vld  = wb.wbs_cyc_i && wb.wbs_stb_i;
      inw  = (adr >= BASE) && (adr < BASE + 32'd16);
      acc  = vld && inw && !m_held;
      m_held = vld && (m_held || acc);
      actw = 1'b0;
      rdv  = 32'd0;
      if (acc) begin
         off = int'((adr - BASE) >> 2);
         case (off)
            0: rdv = {24'd0, m_pending};
            1: rdv = {8'd0, m_pending, m_active, 7'd0, m_busy};
            2: rdv = {24'd0, m_soft};
            default: rdv = {16'd0, m_cnt};
         endcase
         exp_q.push_back(wb.wbs_we_i ? 32'd0 : rdv);
         if (wb.wbs_we_i && wb.wbs_sel_i != 4'd0) begin
            if (off == 0 && wb.wbs_sel_i[0]) actw = 1'b1;
            if (off == 2)
               for (int k = 0; k < NP; k++)
                  if (wb.wbs_sel_i[k/8]) m_soft[k] = dat[k];
         end
      end
      if (m_busy && edge_n == m_sw_end && !actw) begin
         m_active = m_pending;
         m_cnt    = m_cnt + 16'd1;
         m_busy   = 1'b0;
      end
      if (actw) begin
         if (m_busy || dat[7:0] != m_active) begin
            m_busy   = 1'b1;
            m_sw_end = edge_n + GAP;
         end
         m_pending = dat[7:0];
      end
      m_ack = acc;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wb_op(logic we, logic [31:0] adr, logic [31:0] dat, logic [3:0] sel, int hold);
      wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
      wb.wbs_adr_i = adr;  wb.wbs_dat_i = dat;  wb.wbs_sel_i = sel;
      for (int i = 0; i < hold; i++) tick();
      wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
      tick();
   endtask

   task automatic shuffle_pads();
      for (int k = 0; k < NP; k++) begin
         p_out[k*IOP +: IOP] = {$urandom(), $urandom()};
         p_oeb[k*IOP +: IOP] = {$urandom(), $urandom()};
      end
      io_in = {$urandom(), $urandom()};
   endtask

   initial begin
      logic [IOP-1:0] e_out, e_oeb;
      logic [W-1:0]   e_in;
      logic [NP-1:0]  e_rst;
      logic           conn;
      forever begin
         @(negedge clk);
         if (started) begin
            chk("ack", W'(wb.wbs_ack_o), W'(m_ack));
            if (wb.wbs_ack_o) begin
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL rdata actual=%h required=no_ack_expected", wb.wbs_dat_o);
               end else begin
                  chk("rdata", W'(wb.wbs_dat_o), W'(exp_q.pop_front()));
               end
            end else begin
               chk("dat_idle", W'(wb.wbs_dat_o), '0);
            end
            conn  = !m_busy && (m_active < NP);
            e_out = '0;
            e_oeb = '1;
            e_in  = '0;
            if (conn) begin
               e_out = p_out[m_active*IOP +: IOP];
               e_oeb = p_oeb[m_active*IOP +: IOP];
               e_in[m_active*IOP +: IOP] = io_in;
            end
            for (int k = 0; k < NP; k++)
               e_rst[k] = !rst_n || m_soft[k] || m_busy || (m_active != 8'(k));
            chk("io_out", W'(io_out), W'(e_out));
            chk("io_oeb", W'(io_oeb), W'(e_oeb));
            chk("proj_io_in", p_in, e_in);
            chk("proj_rst", W'(p_rst), W'(e_rst));
         end
      end
   end

   initial begin
      int r;
      logic [3:0] sel;
      wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
      wb.wbs_sel_i = 4'd0; wb.wbs_adr_i = 32'd0; wb.wbs_dat_i = 32'd0;
      shuffle_pads();
      p_out[0 +: IOP] = IOP'(8'h15);
      p_oeb[0 +: IOP] = '0;
      idle(2);
      rst_n = 1'b1;
      idle(3);
      wb_op(1'b0, BASE + 32'h0, 32'd0, 4'hF, 1);
      wb_op(1'b0, BASE + 32'h4, 32'd0, 4'hF, 1);
      wb_op(1'b1, BASE + 32'h0, 32'd3, 4'h1, 1);
      idle(20);
      wb_op(1'b0, BASE + 32'hC, 32'd0, 4'hF, 1);
      wb_op(1'b1, BASE + 32'h0, 32'd2, 4'h1, 1);
      idle(4);
      wb_op(1'b1, BASE + 32'h0, 32'd5, 4'h1, 1);
      wb_op(1'b0, BASE + 32'h4, 32'd0, 4'hF, 1);
      idle(20);
      wb_op(1'b1, BASE + 32'h0, 32'd9, 4'h1, 1);
      idle(20);
      wb_op(1'b0, BASE + 32'h0, 32'd0, 4'hF, 1);
      wb_op(1'b1, BASE + 32'h0, 32'd0, 4'h1, 1);
      idle(20);
      wb_op(1'b1, BASE + 32'h8, 32'h1, 4'b0001, 1);
      wb_op(1'b0, BASE + 32'h8, 32'd0, 4'hF, 1);
      wb_op(1'b0, BASE + 32'h10, 32'd0, 4'hF, 1);
      wb_op(1'b0, BASE + 32'h14, 32'd0, 4'hF, 1);
      wb_op(1'b1, BASE + 32'h8, 32'h0, 4'b0001, 1);
      wb_op(1'b0, BASE + 32'h4, 32'd0, 4'hF, 4);
      wb_op(1'b1, BASE + 32'h0, 32'd4, 4'h1, 1);
      idle(5);
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(3);
      for (int n = 0; n < 60; n++) begin
         r   = $urandom_range(0, 9);
         sel = 4'($urandom_range(0, 15));
         if (r <= 3)
            wb_op(1'b1, BASE, {$urandom_range(0, 255) << 8 | 32'($urandom_range(0, 9))},
                  (r == 3) ? sel : (sel | 4'h1), 1);
         else if (r <= 5)
            wb_op(1'b1, BASE + 32'h8, $urandom(), sel, 1);
         else if (r <= 7)
            wb_op(1'b0, BASE + 32'(4 * $urandom_range(0, 3)), 32'd0, sel, $urandom_range(1, 3));
         else if (r == 8)
            wb_op(1'b0, ($urandom_range(0, 1) == 1) ? BASE - 32'd4 : BASE + 32'(16 + 4 * $urandom_range(0, 3)),
                  32'd0, 4'hF, $urandom_range(1, 2));
         else
            wb_op(1'b1, BASE + (($urandom_range(0, 1) == 1) ? 32'h4 : 32'hC), $urandom(), 4'hF, 1);
         if ($urandom_range(0, 3) == 0) shuffle_pads();
         idle($urandom_range(0, 20));
      end
      idle(20);
      chk("leftover_expected_acks", W'(exp_q.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
